opti_sos_cascade: RTL and testbench
===================================

// Module: opti_sos_cascade
// PURPOSE
//  Parametrised cascade of NUM_SEC Direct-Form-I biquads sharing one time-multiplexed multiply-accumulator.
//  Per-section coefficient register file; per-section x/y history; valid/ready on both sample ports.
//  Sits where a single fixed-width biquad sat; provides correct per-sample feedback ordering, rounding and a sticky saturation flag.
// PARAMETERS
//  DATA_W   24  sample width, signed, Q(DATA_W-1-FRAC_W).FRAC_W
//  COEF_W   24  coefficient width, signed
//  FRAC_W   22  coefficient fractional bits; 1.0 = 1<<FRAC_W
//  NUM_SEC  4   number of cascaded sections (1..16)
//  ACC_GRD  4   accumulator guard bits; ACC_W = DATA_W+COEF_W+ACC_GRD
// PORTS
//  clk         in  1       clock
//  rst_n       in  1       async active-low reset
//  in_valid    in  1       input sample valid
//  in_ready    out 1       high only in IDLE
//  in_data     in  DATA_W  input sample
//  out_valid   out 1       output sample valid, held until out_ready
//  out_ready   in  1       downstream accept
//  out_data    out DATA_W  filtered sample, stable while out_valid
//  coef_we     in  1       coefficient write strobe
//  coef_addr   in  clog2(5*NUM_SEC)  sec*5+tap; tap 0..4 = b0,b1,b2,a1,a2
//  coef_wdata  in  COEF_W  coefficient value
//  coef_ready  out 1       high only in IDLE; writes with coef_ready low are dropped
//  hist_clr    in  1       zero all histories and sat_flag
//  sat_flag    out 1       sticky: any section output clamped since reset/hist_clr
//  busy        out 1       high in RUN/WB/OUT
// BEHAVIOUR
//  Single clock domain; clk and async active-low rst_n.
//  Reset: in_ready=1, out_valid=0, out_data=0, coef_ready=1, sat_flag=0, busy=0.
//  Reset also zeroes all histories and loads coefficients to passthrough: b0=1<<FRAC_W, others 0.
//  Reset mid-sample aborts the sample; no output produced.
//  FSM:
//   IDLE -(in_valid)-> RUN: capture in_data as section-0 input; sec=0, tap=0, acc=0.
//   RUN: one MAC per cycle, taps 0..4 on x,x1,x2,y1,y2. b terms add, a terms subtract. tap 4 -> WB.
//   WB: ysat = sat(rnd(acc)>>>FRAC_W) to DATA_W. Updates x2<=x1, x1<=x, y2<=y1, y1<=ysat for sec.
//       Then either sec<NUM_SEC-1: next input=ysat, sec++, -> RUN; or out_data<=ysat, -> OUT.
//   OUT: out_valid=1; on out_ready -> IDLE (in_ready rises next cycle).
//  Latency: handshake in cycle 0 -> out_valid in cycle 6*NUM_SEC+1.
//  Minimum sample period 6*NUM_SEC+2 cycles.
//  Arithmetic: product DATA_W+COEF_W signed, sign-extended into ACC_W; no wrap inside ACC_W.
//  Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; clamp sets sat_flag.
//   The clamped value goes both to history and onward to the next section.
//  hist_clr in IDLE: takes effect next cycle.
//   Asserted while busy: latched, applied on the OUT->IDLE transition; current sample finishes with old history.
//  coef_we and in_valid both high in IDLE: coefficient write lands; sample is captured and uses the new coefficient.
// CONFIGURATION
//  OPTI_SOS_ROUND_EN defined: add 1<<(FRAC_W-1) before the arithmetic shift (round half up).
//  Not defined: plain arithmetic shift (floor); no rounding adder is built.
// STRUCTURE
//  opti_sos_pkg: FSM state enum, TAP_B0..TAP_A2 constants, coef_one(FRAC_W), saturate function.
//  Sub-module opti_sos_mac: multiply, accumulate/clear, round, shift, saturate. Outputs ysat and sat_hit.
//  Top module holds FSM, coefficient file, history arrays.
// TESTING
//  1 Passthrough after reset, NUM_SEC=4: in 1000 -> out 1000 at cycle 25; in -5 -> out -5; sat_flag stays 0.
//  2 Sec0 b0=2097152, a1=-2097152, others passthrough: impulse 4000,0,0 -> 2000,1000,500.
//  3 Saturation: sec0 b0=8388607 (~2.0); in 8388607 -> out 8388607, sat_flag=1.
//    hist_clr -> sat_flag=0, histories zeroed.
//  4 Backpressure: out_ready low 10 cycles -> out_valid/out_data held, in_ready=0.
//    in_valid during hold is not accepted.
//  5 coef_we while busy -> dropped (readback via passthrough result unchanged).
//    hist_clr while busy -> applied only after the sample is accepted.
//  6 Sec0 b0=2097152: in 3 / -3 -> 2 / -1 with OPTI_SOS_ROUND_EN; 1 / -2 without.
//    rst_n pulse mid-RUN -> out_valid=0, next sample sees passthrough.

Source files
------------

// File: rtl/opti_sos_pkg.sv
// Shared definitions for the opti_sos biquad cascade: FSM state codes,
// coefficient tap indices, unity-coefficient helper and output clamp.
package opti_sos_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // Tap order inside one section: feed-forward terms first, then feedback
  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;
  localparam int         NTAP   = 5;

  // Unity gain for a coefficient with frac_w fractional bits
  function automatic logic [63:0] coef_one(input int frac_w);
    return 64'd1 << frac_w;
  endfunction

  // Clamp a signed value to the range of a dw-bit signed word
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/opti_sos_mac.sv
// Shared multiply-accumulator for the biquad cascade. Accumulates signed
// coef*data products (add or subtract), then rounds, shifts down by FRAC_W
// and clamps to DATA_W. Rounding adder exists only with OPTI_SOS_ROUND_EN.
import opti_sos_pkg::*;

module opti_sos_mac #(
  parameter int DATA_W  = 24,
  parameter int COEF_W  = 24,
  parameter int FRAC_W  = 22,
  parameter int ACC_GRD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              sub,
  input  logic [COEF_W-1:0] coef,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] ysat,
  output logic              sat_hit
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + ACC_GRD;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shr;
  logic signed [63:0]       shr64;
  logic signed [63:0]       clip;

  assign prod     = $signed(coef) * $signed(data);
  assign prod_ext = {{ACC_GRD{prod[PROD_W-1]}}, prod};

`ifdef OPTI_SOS_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_K = ACC_W'(1) << (FRAC_W - 1);
  assign rnd = acc + RND_K;
`else
  assign rnd = acc;
`endif

  assign shr     = rnd >>> FRAC_W;
  assign shr64   = {{(64-ACC_W){shr[ACC_W-1]}}, shr};
  assign clip    = saturate(shr64, DATA_W);
  assign ysat    = clip[DATA_W-1:0];
  assign sat_hit = (clip != shr64);

  // Accumulator: cleared between sections, one product per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sub ? acc - prod_ext : acc + prod_ext;
  end

endmodule

// File: rtl/opti_sos_cascade.sv
// Cascade of NUM_SEC Direct-Form-I biquads time-sharing one MAC.
// Holds the sample FSM, the per-section coefficient file and x/y histories.
// Optional round-half-up before the output shift: define OPTI_SOS_ROUND_EN.
import opti_sos_pkg::*;

module opti_sos_cascade #(
  parameter int DATA_W  = 24,
  parameter int COEF_W  = 24,
  parameter int FRAC_W  = 22,
  parameter int NUM_SEC = 4,
  parameter int ACC_GRD = 4,
  localparam int NCOEF  = NTAP * NUM_SEC,
  localparam int AW     = $clog2(NCOEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              coef_ready,
  input  logic              hist_clr,
  output logic              sat_flag,
  output logic              busy
);
  localparam int SW = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
  localparam logic [COEF_W-1:0] ONE = COEF_W'(coef_one(FRAC_W));

  logic [1:0]        state;
  logic [SW-1:0]     sec;
  logic [2:0]        tap;
  logic [DATA_W-1:0] x_cur;
  logic              clr_pend;

  logic [COEF_W-1:0] coef_mem [NCOEF];
  logic [DATA_W-1:0] x1 [NUM_SEC];
  logic [DATA_W-1:0] x2 [NUM_SEC];
  logic [DATA_W-1:0] y1 [NUM_SEC];
  logic [DATA_W-1:0] y2 [NUM_SEC];

  logic [AW-1:0]     cidx;
  logic [DATA_W-1:0] op;
  logic [DATA_W-1:0] ysat;
  logic              sat_hit;
  logic              in_fire, out_fire, coef_wr, hist_zero, last_sec;

  assign in_ready   = (state == ST_IDLE);
  assign coef_ready = (state == ST_IDLE);
  assign out_valid  = (state == ST_OUT);
  assign busy       = (state != ST_IDLE);
  assign in_fire    = in_ready && in_valid;
  assign out_fire   = out_valid && out_ready;
  assign coef_wr    = coef_we && coef_ready && (int'(coef_addr) < NCOEF);
  assign last_sec   = (int'(sec) == NUM_SEC - 1);
  // Histories clear immediately in IDLE; a request seen while busy waits
  // until the finished sample is handed off so that sample keeps old state.
  assign hist_zero  = (in_ready && hist_clr) || (out_fire && (clr_pend || hist_clr));

  // Select coefficient and operand for the current tap
  always_comb begin
    cidx = AW'(int'(sec) * NTAP + int'(tap));
    op   = '0;
    case (tap)
      TAP_B0:  op = x_cur;
      TAP_B1:  op = x1[sec];
      TAP_B2:  op = x2[sec];
      TAP_A1:  op = y1[sec];
      default: op = y2[sec];
    endcase
  end

  opti_sos_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .FRAC_W (FRAC_W),
    .ACC_GRD(ACC_GRD)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (in_fire || (state == ST_WB)),
    .en     (state == ST_RUN),
    .sub    (tap >= TAP_A1),
    .coef   (coef_mem[cidx]),
    .data   (op),
    .ysat   (ysat),
    .sat_hit(sat_hit)
  );

  // Sample FSM: capture, five MACs per section, write-back, hold output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sec      <= '0;
      tap      <= TAP_B0;
      x_cur    <= '0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          x_cur <= in_data;
          sec   <= '0;
          tap   <= TAP_B0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (tap == TAP_A2) state <= ST_WB;
          else               tap   <= tap + 3'd1;
        end
        ST_WB: begin
          tap <= TAP_B0;
          if (!last_sec) begin
            x_cur <= ysat;
            sec   <= sec + 1'b1;
            state <= ST_RUN;
          end else begin
            out_data <= ysat;
            state    <= ST_OUT;
          end
        end
        default: if (out_ready) state <= ST_IDLE;
      endcase
    end
  end

  // Coefficient file: passthrough on reset, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEF; i++) coef_mem[i] <= (i % NTAP == 0) ? ONE : '0;
    end else if (coef_wr) begin
      coef_mem[coef_addr] <= coef_wdata;
    end
  end

  // Per-section delay lines, shifted once at each section write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEC; i++) begin
        x1[i] <= '0; x2[i] <= '0; y1[i] <= '0; y2[i] <= '0;
      end
    end else if (hist_zero) begin
      for (int i = 0; i < NUM_SEC; i++) begin
        x1[i] <= '0; x2[i] <= '0; y1[i] <= '0; y2[i] <= '0;
      end
    end else if (state == ST_WB) begin
      x2[sec] <= x1[sec];
      x1[sec] <= x_cur;
      y2[sec] <= y1[sec];
      y1[sec] <= ysat;
    end
  end

  // Sticky saturation flag and deferred history-clear request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      if (hist_zero)                          sat_flag <= 1'b0;
      else if ((state == ST_WB) && sat_hit)   sat_flag <= 1'b1;
      if (out_fire)                           clr_pend <= 1'b0;
      else if (hist_clr && busy)              clr_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_opti_sos_cascade.sv
// Directed bench for opti_sos_cascade: a table of coefficient writes,
// history clears and samples with hand-computed results, followed by
// sequences for backpressure, writes while busy and reset mid-sample.
module tb_opti_sos_cascade;
  localparam int DW = 24, CW = 24, FW = 22, NS = 4, GRD = 4;
  localparam int AW = $clog2(5 * NS);
  localparam int LAT = 6 * NS + 1;
  localparam int K_COEF = 0, K_CLR = 1, K_SAMP = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0, out_ready = 1'b0, coef_we = 1'b0, hist_clr = 1'b0;
  logic [DW-1:0]        in_data = '0;
  logic [AW-1:0]        coef_addr = '0;
  logic [CW-1:0]        coef_wdata = '0;
  logic                 in_ready, out_valid, coef_ready, sat_flag, busy;
  logic signed [DW-1:0] out_data;

  int checks = 0, failures = 0;

  typedef struct {
    int    kind;
    int    addr;
    int    data;
    int    expv;
    int    exps;
    string name;
  } vec_t;
  vec_t vecs[$];

  opti_sos_cascade #(.DATA_W(DW), .COEF_W(CW), .FRAC_W(FW), .NUM_SEC(NS), .ACC_GRD(GRD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_ready(coef_ready),
    .hist_clr(hist_clr), .sat_flag(sat_flag), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic add(input int kind, input int addr, input int data, input int expv, input int exps, input string name);
    vec_t v;
    v.kind = kind; v.addr = addr; v.data = data; v.expv = expv; v.exps = exps; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic wr_coef(input int addr, input int data);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_wdata = CW'(data);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
  endtask

  // Present a sample and return at the negedge after the handshake edge
  task automatic start(input int din);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = DW'(din);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; lat counts cycles with the handshake cycle as 0
  task automatic wait_out(input int lat0, output int lat);
    lat = lat0;
    while (!out_valid && lat < 400) begin @(negedge clk); lat++; end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic send(input int din, output int dout, output int lat);
    start(din);
    wait_out(1, lat);
    dout = int'(out_data);
    accept();
  endtask

  initial begin
    int dout, lat;
    int r_pos, r_neg;
`ifdef OPTI_SOS_ROUND_EN
    r_pos = 2; r_neg = -1;
`else
    r_pos = 1; r_neg = -2;
`endif

    // Passthrough after reset
    add(K_SAMP, 0, 1000, 1000, 0, "pt_1000");
    add(K_SAMP, 0, -5, -5, 0, "pt_neg5");
    // First-order recursion in section 0: y = 0.5x + 0.5y1
    add(K_CLR, 0, 0, 0, 0, "clr_a");
    add(K_COEF, 0, 2097152, 0, 0, "");
    add(K_COEF, 3, -2097152, 0, 0, "");
    add(K_SAMP, 0, 4000, 2000, 0, "iir_0");
    add(K_SAMP, 0, 0, 1000, 0, "iir_1");
    add(K_SAMP, 0, 0, 500, 0, "iir_2");
    // Gain ~2.0 drives the first section into the clamp
    add(K_COEF, 3, 0, 0, 0, "");
    add(K_COEF, 0, 8388607, 0, 0, "");
    add(K_SAMP, 0, 8388607, 8388607, 1, "sat_hi");
    add(K_CLR, 0, 0, 0, 0, "clr_sat");
    // Pure delay y = x1 shows the history was zeroed
    add(K_COEF, 0, 0, 0, 0, "");
    add(K_COEF, 1, 4194304, 0, 0, "");
    add(K_SAMP, 0, 7, 0, 0, "dly_after_clr");
    add(K_SAMP, 0, 9, 7, 0, "dly_next");
    // Half gain: rounding versus floor
    add(K_COEF, 1, 0, 0, 0, "");
    add(K_COEF, 0, 2097152, 0, 0, "");
    add(K_SAMP, 0, 3, r_pos, 0, "rnd_pos3");
    add(K_SAMP, 0, -3, r_neg, 0, "rnd_neg3");
    add(K_COEF, 0, 4194304, 0, 0, "");

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_coef_ready", coef_ready, 1);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_COEF: wr_coef(vecs[i].addr, vecs[i].data);
        K_CLR: begin
          do_clr();
          chk({vecs[i].name, "_sat"}, sat_flag, 0);
        end
        default: begin
          send(vecs[i].data, dout, lat);
          chk({vecs[i].name, "_lat"}, lat, LAT);
          chk(vecs[i].name, dout, vecs[i].expv);
          chk({vecs[i].name, "_sat"}, sat_flag, vecs[i].exps);
        end
      endcase
    end

    // Backpressure: output and in_ready held, a waiting input not taken
    start(321);
    wait_out(1, lat);
    chk("bp_lat", lat, LAT);
    in_valid = 1'b1; in_data = DW'(999);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 321);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    accept();
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_busy", busy, 0);

    // Coefficient write while busy is dropped
    start(100);
    @(negedge clk);
    chk("busy_coef_ready", coef_ready, 0);
    coef_we = 1'b1; coef_addr = AW'(0); coef_wdata = '0;
    @(negedge clk);
    coef_we = 1'b0;
    wait_out(3, lat);
    chk("busy_we_valid", out_valid, 1);
    chk("busy_we_out", out_data, 100);
    accept();
    send(200, dout, lat);
    chk("busy_we_after", dout, 200);

    // History clear while busy waits for the output handoff: y = x + x1
    do_clr();
    wr_coef(1, 4194304);
    send(10, dout, lat);
    chk("hc_first", dout, 10);
    start(20);
    @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    wait_out(3, lat);
    chk("hc_busy_out", out_data, 30);
    accept();
    send(5, dout, lat);
    chk("hc_after", dout, 5);
    wr_coef(1, 0);

    // Reset mid-RUN: aborts the sample and restores passthrough
    wr_coef(0, 2097152);
    start(777);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    send(1234, dout, lat);
    chk("post_rst_lat", lat, LAT);
    chk("post_rst_pt", dout, 1234);
    chk("post_rst_sat", sat_flag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
